oversample_frame_capture: RTL and testbench

- Producer side of the oversampled-frame interface consumed by the bit-ranking sorter.
- Samples a serial line at OSF samples per symbol and packs SAMPLES*OSF consecutive samples into one frame word.
- Hands each frame downstream over a valid/ready handshake, with a one-deep holding register and overrun detection.
- Sits between the line input pin and the sorter's DataIn.

---
 rtl/oversample_frame_capture_pkg.sv | 26 ++
 rtl/sync_2ff.sv | 24 ++
 rtl/oversample_frame_capture.sv | 104 ++++++++++
 tb/tb_oversample_frame_capture.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/oversample_frame_capture_pkg.sv
// Shared widths and types for the oversampled-frame interface (capture side and sorter).
package oversample_frame_capture_pkg;

    localparam int unsigned DEF_SAMPLES = 2;
    localparam int unsigned DEF_OSF     = 8;

    function automatic int unsigned frame_bits(input int unsigned samples, input int unsigned osf);
        return samples * osf;
    endfunction

    // One extra bit so an all-ones frame count (== N) fits.
    function automatic int unsigned count_bits(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

    localparam int unsigned FRAME_N  = frame_bits(DEF_SAMPLES, DEF_OSF);
    localparam int unsigned FRAME_CW = count_bits(FRAME_N);

    typedef logic [FRAME_N-1:0] frame_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } cap_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input; synchronous active-high reset.
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/oversample_frame_capture.sv
// Packs SAMPLES*OSF oversampled line samples into frames and offers them on valid/ready
// through a one-deep holding register with sticky overrun.
module oversample_frame_capture
    import oversample_frame_capture_pkg::*;
#(
    parameter  int unsigned SAMPLES = DEF_SAMPLES,
    parameter  int unsigned OSF     = DEF_OSF,
    localparam int unsigned N       = frame_bits(SAMPLES, OSF),
    localparam int unsigned CW      = count_bits(N)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          SerIn,
    input  logic          SampleEn,
    input  logic          Enable,
    input  logic          FrameReady,
    input  logic          ClearOvr,
    output logic [N-1:0]  DataOut,
    output logic [CW-1:0] OnesCount,
    output logic          FrameValid,
    output logic          Overrun,
    output logic          Busy
);

    cap_state_t    r_state;
    cap_state_t    w_next;
    logic [CW-1:0] r_count;
    logic [N-2:0]  r_shift;
    logic          w_s_sync;
    logic          w_sample;
    logic          w_done;
    logic [N-1:0]  w_word;
    logic [CW-1:0] w_ones;

    sync_2ff u_sync (
        .i_clk (Clk),
        .i_rst (Reset),
        .i_d   (SerIn),
        .o_q   (w_s_sync)
    );

    always_ff @(posedge Clk) begin
        if (Reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (Enable)  w_next = ST_FILL;
            ST_FILL: if (!Enable) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Enable low in FILL discards the partial frame, even if SampleEn is high on that edge.
    assign w_sample = (r_state == ST_FILL) && Enable && SampleEn;
    assign w_done   = w_sample && (r_count == CW'(N - 1));
    assign w_word   = {r_shift, w_s_sync};

    always_comb begin
        w_ones = '0;
        for (int unsigned i = 0; i < N; i++) begin
            w_ones = w_ones + CW'(w_word[i]);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset || (r_state != ST_FILL) || !Enable) begin
            r_count <= '0;
            r_shift <= '0;
        end else if (w_sample) begin
            r_shift <= w_word[N-2:0];
            r_count <= w_done ? '0 : r_count + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            DataOut    <= '0;
            OnesCount  <= '0;
            FrameValid <= 1'b0;
            Overrun    <= 1'b0;
        end else begin
            if (w_done && (!FrameValid || FrameReady)) begin
                DataOut    <= w_word;
                OnesCount  <= w_ones;
                FrameValid <= 1'b1;
            end else if (FrameValid && FrameReady) begin
                FrameValid <= 1'b0;
            end

            // A drop on the same edge as ClearOvr keeps the flag set.
            if (w_done && FrameValid && !FrameReady) begin
                Overrun <= 1'b1;
            end else if (ClearOvr) begin
                Overrun <= 1'b0;
            end
        end
    end

    assign Busy = (r_state == ST_FILL) && (r_count != '0);

endmodule

// File: tb/tb_oversample_frame_capture.sv
// Directed bench for oversample_frame_capture with SAMPLES=2, OSF=8 (N=16, CW=5).
module tb_oversample_frame_capture;
    import oversample_frame_capture_pkg::*;

    logic                Clk = 1'b0;
    logic                Reset = 1'b1;
    logic                SerIn = 1'b0;
    logic                SampleEn = 1'b0;
    logic                Enable = 1'b0;
    logic                FrameReady = 1'b0;
    logic                ClearOvr = 1'b0;
    frame_t              DataOut;
    logic [FRAME_CW-1:0] OnesCount;
    logic                FrameValid;
    logic                Overrun;
    logic                Busy;

    int checks   = 0;
    int failures = 0;

    oversample_frame_capture #(.SAMPLES(2), .OSF(8)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .SerIn      (SerIn),
        .SampleEn   (SampleEn),
        .Enable     (Enable),
        .FrameReady (FrameReady),
        .ClearOvr   (ClearOvr),
        .DataOut    (DataOut),
        .OnesCount  (OnesCount),
        .FrameValid (FrameValid),
        .Overrun    (Overrun),
        .Busy       (Busy)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // Holds SerIn long enough to cross the synchronizer, then strobes one sample.
    task automatic send_sample(input logic b, input int gap, input logic rdy);
        @(negedge Clk);
        SerIn    = b;
        SampleEn = 1'b0;
        repeat (2 + gap) @(posedge Clk);
        @(negedge Clk);
        SampleEn   = 1'b1;
        FrameReady = rdy;
        @(posedge Clk);
        #1;
        SampleEn = 1'b0;
    endtask

    task automatic send_frame(input frame_t w, input logic rdy_mid, input logic rdy_last);
        for (int i = FRAME_N - 1; i >= 1; i--) send_sample(w[i], 0, rdy_mid);
        send_sample(w[0], 0, rdy_last);
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        SerIn = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        checks++; if (DataOut !== 16'h0000) begin failures++; $display("FAIL reset_data got=%h exp=0000", DataOut); end
        checks++; if (OnesCount !== 5'd0) begin failures++; $display("FAIL reset_ones got=%0d exp=0", OnesCount); end
        checks++; if (FrameValid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", FrameValid); end
        checks++; if (Overrun !== 1'b0) begin failures++; $display("FAIL reset_ovr got=%b exp=0", Overrun); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", Busy); end
        Reset = 1'b0;
    endtask

    task automatic test_basic;
        frame_t w;
        w = 16'hFF00;
        @(negedge Clk);
        Enable = 1'b1;
        send_sample(w[15], 0, 1'b0);
        checks++; if (Busy !== 1'b1) begin failures++; $display("FAIL basic_busy_mid got=%b exp=1", Busy); end
        for (int i = 14; i >= 0; i--) send_sample(w[i], 0, 1'b0);
        checks++; if (DataOut !== 16'hFF00) begin failures++; $display("FAIL basic_data got=%h exp=ff00", DataOut); end
        checks++; if (OnesCount !== 5'd8) begin failures++; $display("FAIL basic_ones got=%0d exp=8", OnesCount); end
        checks++; if (FrameValid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", FrameValid); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL basic_busy_end got=%b exp=0", Busy); end
        repeat (3) @(posedge Clk);
        #1;
        checks++; if (FrameValid !== 1'b1) begin failures++; $display("FAIL basic_hold_valid got=%b exp=1", FrameValid); end
        @(negedge Clk);
        FrameReady = 1'b1;
        @(posedge Clk);
        #1;
        FrameReady = 1'b0;
        checks++; if (FrameValid !== 1'b0) begin failures++; $display("FAIL basic_xfer_valid got=%b exp=0", FrameValid); end
    endtask

    task automatic test_back_to_back;
        send_frame(16'hAAAA, 1'b1, 1'b1);
        checks++; if (DataOut !== 16'hAAAA) begin failures++; $display("FAIL b2b_data0 got=%h exp=aaaa", DataOut); end
        checks++; if (OnesCount !== 5'd8) begin failures++; $display("FAIL b2b_ones0 got=%0d exp=8", OnesCount); end
        checks++; if (FrameValid !== 1'b1) begin failures++; $display("FAIL b2b_valid0 got=%b exp=1", FrameValid); end
        send_frame(16'h0001, 1'b1, 1'b1);
        checks++; if (DataOut !== 16'h0001) begin failures++; $display("FAIL b2b_data1 got=%h exp=0001", DataOut); end
        checks++; if (OnesCount !== 5'd1) begin failures++; $display("FAIL b2b_ones1 got=%0d exp=1", OnesCount); end
        checks++; if (Overrun !== 1'b0) begin failures++; $display("FAIL b2b_ovr got=%b exp=0", Overrun); end
        FrameReady = 1'b0;
        // Transfer and reload on the same edge: valid never drops between frames.
        send_frame(16'h1234, 1'b0, 1'b1);
        checks++; if (DataOut !== 16'h1234) begin failures++; $display("FAIL b2b_data2 got=%h exp=1234", DataOut); end
        checks++; if (OnesCount !== 5'd5) begin failures++; $display("FAIL b2b_ones2 got=%0d exp=5", OnesCount); end
        checks++; if (FrameValid !== 1'b1) begin failures++; $display("FAIL b2b_valid2 got=%b exp=1", FrameValid); end
        checks++; if (Overrun !== 1'b0) begin failures++; $display("FAIL b2b_ovr2 got=%b exp=0", Overrun); end
        FrameReady = 1'b0;
    endtask

    task automatic test_overrun;
        send_frame(16'h00FF, 1'b0, 1'b0);
        checks++; if (DataOut !== 16'h1234) begin failures++; $display("FAIL ovr_data_kept got=%h exp=1234", DataOut); end
        checks++; if (OnesCount !== 5'd5) begin failures++; $display("FAIL ovr_ones_kept got=%0d exp=5", OnesCount); end
        checks++; if (FrameValid !== 1'b1) begin failures++; $display("FAIL ovr_valid got=%b exp=1", FrameValid); end
        checks++; if (Overrun !== 1'b1) begin failures++; $display("FAIL ovr_set got=%b exp=1", Overrun); end
        @(negedge Clk);
        ClearOvr = 1'b1;
        @(posedge Clk);
        #1;
        ClearOvr = 1'b0;
        checks++; if (Overrun !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%b exp=0", Overrun); end
        ClearOvr = 1'b1;
        send_frame(16'h0F0F, 1'b0, 1'b0);
        ClearOvr = 1'b0;
        checks++; if (Overrun !== 1'b1) begin failures++; $display("FAIL ovr_set_wins got=%b exp=1", Overrun); end
        checks++; if (DataOut !== 16'h1234) begin failures++; $display("FAIL ovr_data_kept2 got=%h exp=1234", DataOut); end
        @(negedge Clk);
        ClearOvr   = 1'b1;
        FrameReady = 1'b1;
        @(posedge Clk);
        #1;
        ClearOvr   = 1'b0;
        FrameReady = 1'b0;
        checks++; if (FrameValid !== 1'b0) begin failures++; $display("FAIL ovr_drain_valid got=%b exp=0", FrameValid); end
        checks++; if (Overrun !== 1'b0) begin failures++; $display("FAIL ovr_drain_ovr got=%b exp=0", Overrun); end
    endtask

    task automatic test_abort;
        for (int i = 0; i < 9; i++) send_sample(1'b0, 0, 1'b0);
        checks++; if (Busy !== 1'b1) begin failures++; $display("FAIL abort_busy_partial got=%b exp=1", Busy); end
        @(negedge Clk);
        Enable = 1'b0;
        @(posedge Clk);
        #1;
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL abort_busy_idle got=%b exp=0", Busy); end
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            SampleEn = 1'b1;
            @(posedge Clk);
            #1;
            SampleEn = 1'b0;
        end
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL abort_idle_ignores got=%b exp=0", Busy); end
        @(negedge Clk);
        Enable = 1'b1;
        for (int i = 0; i < 15; i++) send_sample(1'b1, 0, 1'b0);
        checks++; if (FrameValid !== 1'b0) begin failures++; $display("FAIL abort_no_early got=%b exp=0", FrameValid); end
        send_sample(1'b1, 0, 1'b0);
        checks++; if (DataOut !== 16'hFFFF) begin failures++; $display("FAIL abort_data got=%h exp=ffff", DataOut); end
        checks++; if (OnesCount !== 5'b10000) begin failures++; $display("FAIL abort_ones got=%0d exp=16", OnesCount); end
        checks++; if (FrameValid !== 1'b1) begin failures++; $display("FAIL abort_valid got=%b exp=1", FrameValid); end
    endtask

    task automatic test_reset_mid;
        frame_t w;
        w = 16'h5A5A;
        for (int i = 0; i < 5; i++) send_sample(1'b1, 0, 1'b0);
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        checks++; if (DataOut !== 16'h0000) begin failures++; $display("FAIL rmid_data got=%h exp=0000", DataOut); end
        checks++; if (OnesCount !== 5'd0) begin failures++; $display("FAIL rmid_ones got=%0d exp=0", OnesCount); end
        checks++; if (FrameValid !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%b exp=0", FrameValid); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", Busy); end
        Reset = 1'b0;
        for (int i = 15; i >= 1; i--) send_sample(w[i], 0, 1'b0);
        checks++; if (FrameValid !== 1'b0) begin failures++; $display("FAIL rmid_no_early got=%b exp=0", FrameValid); end
        send_sample(w[0], 0, 1'b0);
        checks++; if (DataOut !== 16'h5A5A) begin failures++; $display("FAIL rmid_data2 got=%h exp=5a5a", DataOut); end
        checks++; if (OnesCount !== 5'd8) begin failures++; $display("FAIL rmid_ones2 got=%0d exp=8", OnesCount); end
    endtask

    task automatic test_gaps;
        frame_t w;
        int gaps[16] = '{0, 3, 18, 1, 0, 5, 2, 0, 7, 1, 4, 0, 2, 6, 0, 3};
        w = 16'h8001;
        for (int i = 0; i < 16; i++) send_sample(w[15 - i], gaps[i], 1'b1);
        checks++; if (DataOut !== 16'h8001) begin failures++; $display("FAIL gaps_data got=%h exp=8001", DataOut); end
        checks++; if (OnesCount !== 5'd2) begin failures++; $display("FAIL gaps_ones got=%0d exp=2", OnesCount); end
        checks++; if (FrameValid !== 1'b1) begin failures++; $display("FAIL gaps_valid got=%b exp=1", FrameValid); end
        checks++; if (DataOut[15] !== 1'b1) begin failures++; $display("FAIL gaps_first_bit15 got=%b exp=1", DataOut[15]); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_overrun();
        test_abort();
        test_reset_mid();
        test_gaps();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
